// File: rtl/mux_scan_nto1.sv
// N-to-1 channel multiplexer with a registered valid/ready output port.
// Direct mode reads one addressed channel; scan mode walks every channel enabled in a mask.
module mux_scan_nto1 #(
    parameter int N     = 8,
    parameter int W     = 8,
    parameter int SEL_W = $clog2(N)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N*W-1:0]       io_in,
    input  logic [SEL_W-1:0]     io_sel,
    input  logic                 io_mode,
    input  logic [N-1:0]         io_mask,
    input  logic                 io_start,
    output logic [W-1:0]         io_out,
    output logic [SEL_W-1:0]     io_out_ch,
    output logic                 io_out_valid,
    input  logic                 io_out_ready,
    output logic                 io_busy,
    output logic                 io_done,
    output logic                 io_err
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [SEL_W:0] N_LIM = (SEL_W+1)'(N);

    state_t           state_r;
    logic [W-1:0]     out_r;
    logic [SEL_W-1:0] out_ch_r;
    logic             valid_r;
    logic             done_r;
    logic             err_r;
    logic             mode_r;
    logic [N-1:0]     mask_r;

    logic [N-1:0]     above_s;
    logic [SEL_W:0]   first_s;
    logic [SEL_W:0]   next_s;
    logic             sel_ok_s;

    // Priority encoder: {found, index of lowest set bit}.
    function automatic logic [SEL_W:0] lowest_set(input logic [N-1:0] m);
        logic [SEL_W:0] r;
        r = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (m[k]) begin
                r = {1'b1, SEL_W'(k)};
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] pick(input logic [N*W-1:0] bus, input logic [SEL_W-1:0] idx);
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) begin
            if (SEL_W'(k) == idx) begin
                r = bus[k*W +: W];
            end
        end
        return r;
    endfunction

    // Candidate channels strictly above the one currently presented.
    always_comb begin
        above_s = '0;
        for (int k = 0; k < N; k++) begin
            above_s[k] = mask_r[k] & (SEL_W'(k) > out_ch_r);
        end
    end

    // Start-of-scan and next-in-scan searches plus direct-select range check.
    always_comb begin
        first_s  = lowest_set(io_mask);
        next_s   = lowest_set(above_s);
        sel_ok_s = ({1'b0, io_sel} < N_LIM);
    end

    // Control FSM and output registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r  <= IDLE;
            out_r    <= '0;
            out_ch_r <= '0;
            valid_r  <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            mode_r   <= 1'b0;
            mask_r   <= '0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (io_start) begin
                        mode_r <= io_mode;
                        if (!io_mode) begin
                            if (sel_ok_s) begin
                                out_r    <= pick(io_in, io_sel);
                                out_ch_r <= io_sel;
                                valid_r  <= 1'b1;
                                state_r  <= HOLD;
                            end else begin
                                err_r  <= 1'b1;
                                done_r <= 1'b1;
                            end
                        end else begin
                            mask_r <= io_mask;
                            if (first_s[SEL_W]) begin
                                out_r    <= pick(io_in, first_s[SEL_W-1:0]);
                                out_ch_r <= first_s[SEL_W-1:0];
                                valid_r  <= 1'b1;
                                state_r  <= HOLD;
                            end else begin
                                done_r <= 1'b1;
                            end
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                HOLD: begin
                    // The word is held untouched until the consumer takes it.
                    if (valid_r && io_out_ready) begin
                        if (mode_r && next_s[SEL_W]) begin
                            out_r    <= pick(io_in, next_s[SEL_W-1:0]);
                            out_ch_r <= next_s[SEL_W-1:0];
                        end else begin
                            valid_r <= 1'b0;
                            done_r  <= 1'b1;
                            state_r <= IDLE;
                        end
                    end else begin
                        state_r <= HOLD;
                    end
                end
                default: begin
                    valid_r <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign io_out       = out_r;
    assign io_out_ch    = out_ch_r;
    assign io_out_valid = valid_r;
    assign io_busy      = (state_r == HOLD);
    assign io_done      = done_r;
    assign io_err       = err_r;

endmodule

// File: tb/tb_mux_scan_nto1.sv
// Scoreboard bench for mux_scan_nto1: an N=8 instance for the main scenarios
// and an N=6 instance for the out-of-range direct select.
module tb_mux_scan_nto1;

    typedef struct {
        int         inst;
        int         kind;   // 0 = word transfer, 1 = done/err pulse
        int         cyc;
        logic [7:0] data;   // done events: {6'b0, done, err}
        logic [2:0] ch;
    } evt_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [63:0] io_in;
    logic [2:0]  io_sel;
    logic        io_mode;
    logic [7:0]  io_mask;
    logic        start8, start6, ready;

    logic [7:0] o8_out, o6_out;
    logic [2:0] o8_ch, o6_ch;
    logic       o8_valid, o8_busy, o8_done, o8_err;
    logic       o6_valid, o6_busy, o6_done, o6_err;

    logic [7:0] m_out   [2];
    logic [2:0] m_ch    [2];
    logic       m_valid [2];
    logic       m_busy  [2];
    logic       m_done  [2];
    logic       m_err   [2];

    evt_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic rst_q = 1'b1;
    logic prev_hold = 1'b0;
    logic [7:0] prev_out = '0;
    logic [2:0] prev_ch = '0;
    int   s;

    mux_scan_nto1 #(.N(8), .W(8)) dut8 (
        .clock(clock), .reset(reset), .io_in(io_in), .io_sel(io_sel),
        .io_mode(io_mode), .io_mask(io_mask), .io_start(start8),
        .io_out(o8_out), .io_out_ch(o8_ch), .io_out_valid(o8_valid),
        .io_out_ready(ready), .io_busy(o8_busy), .io_done(o8_done), .io_err(o8_err)
    );

    mux_scan_nto1 #(.N(6), .W(8)) dut6 (
        .clock(clock), .reset(reset), .io_in(io_in[47:0]), .io_sel(io_sel),
        .io_mode(io_mode), .io_mask(io_mask[5:0]), .io_start(start6),
        .io_out(o6_out), .io_out_ch(o6_ch), .io_out_valid(o6_valid),
        .io_out_ready(ready), .io_busy(o6_busy), .io_done(o6_done), .io_err(o6_err)
    );

    assign m_out[0] = o8_out;   assign m_out[1] = o6_out;
    assign m_ch[0] = o8_ch;     assign m_ch[1] = o6_ch;
    assign m_valid[0] = o8_valid; assign m_valid[1] = o6_valid;
    assign m_busy[0] = o8_busy; assign m_busy[1] = o6_busy;
    assign m_done[0] = o8_done; assign m_done[1] = o6_done;
    assign m_err[0] = o8_err;   assign m_err[1] = o6_err;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    task automatic push_exp(input int inst, input int kind, input int c,
                            input logic [7:0] data, input logic [2:0] ch);
        evt_t e;
        e.inst = inst; e.kind = kind; e.cyc = c; e.data = data; e.ch = ch;
        q.push_back(e);
    endtask

    task automatic observe(input int inst, input int kind, input logic [7:0] data, input logic [2:0] ch);
        evt_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event actual inst=%0d kind=%0d cyc=%0d data=%h ch=%0d required none",
                     inst, kind, cyc, data, ch);
        end else begin
            e = q.pop_front();
            if (e.inst != inst || e.kind != kind || e.cyc != cyc || e.data != data || e.ch != ch) begin
                errors++;
                $display("FAIL event actual inst=%0d kind=%0d cyc=%0d data=%h ch=%0d required inst=%0d kind=%0d cyc=%0d data=%h ch=%0d",
                         inst, kind, cyc, data, ch, e.inst, e.kind, e.cyc, e.data, e.ch);
            end
        end
    endtask

    // Monitor: samples just after the falling edge, once stimulus has settled.
    always @(negedge clock) begin
        #1;
        if (!rst_q) begin
            checks++;
            if ({o8_out, o8_ch, o8_valid, o8_busy, o8_done, o8_err,
                 o6_out, o6_ch, o6_valid, o6_busy, o6_done, o6_err} != 30'd0) begin
                errors++;
                $display("FAIL reset_state cyc=%0d actual out=%h ch=%0d valid=%b busy=%b done=%b err=%b required all zero",
                         cyc, o8_out, o8_ch, o8_valid, o8_busy, o8_done, o8_err);
            end
        end
        if (prev_hold && o8_valid) begin
            checks++;
            if (o8_out != prev_out || o8_ch != prev_ch) begin
                errors++;
                $display("FAIL hold_stable cyc=%0d actual out=%h ch=%0d required out=%h ch=%0d",
                         cyc, o8_out, o8_ch, prev_out, prev_ch);
            end
        end
        prev_hold = o8_valid && !ready;
        prev_out  = o8_out;
        prev_ch   = o8_ch;
        for (int i = 0; i < 2; i++) begin
            if (m_valid[i] && ready) begin
                observe(i, 0, m_out[i], m_ch[i]);
            end
            if (m_done[i] || m_err[i]) begin
                observe(i, 1, {6'b000000, m_done[i], m_err[i]}, 3'd0);
                checks++;
                if (m_busy[i]) begin
                    errors++;
                    $display("FAIL idle_at_done inst=%0d cyc=%0d actual busy=1 required busy=0", i, cyc);
                end
            end
        end
    end

    initial begin
        reset = 1'b0; start8 = 1'b0; start6 = 1'b0;
        io_mode = 1'b0; io_sel = 3'd0; io_mask = 8'h00; ready = 1'b1;
        for (int k = 0; k < 8; k++) io_in[k*8 +: 8] = 8'(16 + k);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // Direct read of channel 5
        s = cyc; io_mode = 1'b0; io_sel = 3'd5; start8 = 1'b1;
        push_exp(0, 0, s + 1, 8'h15, 3'd5);
        push_exp(0, 1, s + 2, 8'h02, 3'd0);
        @(negedge clock) start8 = 1'b0;
        repeat (3) @(negedge clock);

        // Full-rate scan over mask 0b10100101
        s = cyc; io_mode = 1'b1; io_mask = 8'hA5; start8 = 1'b1;
        push_exp(0, 0, s + 1, 8'h10, 3'd0);
        push_exp(0, 0, s + 2, 8'h12, 3'd2);
        push_exp(0, 0, s + 3, 8'h15, 3'd5);
        push_exp(0, 0, s + 4, 8'h17, 3'd7);
        push_exp(0, 1, s + 5, 8'h02, 3'd0);
        @(negedge clock) start8 = 1'b0;
        repeat (6) @(negedge clock);

        // Backpressure on ch2 while io_in[2], io_mask and io_start are disturbed
        s = cyc; io_mode = 1'b1; io_mask = 8'hA5; start8 = 1'b1;
        push_exp(0, 0, s + 1, 8'h10, 3'd0);
        push_exp(0, 0, s + 5, 8'h12, 3'd2);
        push_exp(0, 0, s + 6, 8'h15, 3'd5);
        push_exp(0, 0, s + 7, 8'h17, 3'd7);
        push_exp(0, 1, s + 8, 8'h02, 3'd0);
        @(negedge clock) start8 = 1'b0;
        @(negedge clock);
        ready = 1'b0; io_in[23:16] = 8'hEE; io_mask = 8'h02; start8 = 1'b1;
        @(negedge clock) start8 = 1'b0;
        @(negedge clock);
        @(negedge clock) ready = 1'b1;
        repeat (5) @(negedge clock);
        io_in[23:16] = 8'h12; io_mask = 8'hA5;
        @(negedge clock);

        // Empty scan mask
        s = cyc; io_mode = 1'b1; io_mask = 8'h00; start8 = 1'b1;
        push_exp(0, 1, s + 1, 8'h02, 3'd0);
        @(negedge clock) start8 = 1'b0;
        repeat (2) @(negedge clock);

        // N=6: out-of-range direct select, then an in-range one
        s = cyc; io_mode = 1'b0; io_sel = 3'd7; start6 = 1'b1;
        push_exp(1, 1, s + 1, 8'h03, 3'd0);
        @(negedge clock) start6 = 1'b0;
        repeat (2) @(negedge clock);
        s = cyc; io_sel = 3'd3; start6 = 1'b1;
        push_exp(1, 0, s + 1, 8'h13, 3'd3);
        push_exp(1, 1, s + 2, 8'h02, 3'd0);
        @(negedge clock) start6 = 1'b0;
        repeat (3) @(negedge clock);

        // Reset while ch2 is held, then a fresh scan restarts at the lowest channel
        s = cyc; io_mode = 1'b1; io_mask = 8'hA5; start8 = 1'b1;
        push_exp(0, 0, s + 1, 8'h10, 3'd0);
        @(negedge clock) start8 = 1'b0;
        @(negedge clock) begin ready = 1'b0; reset = 1'b0; end
        @(negedge clock) begin ready = 1'b1; reset = 1'b1; end
        @(negedge clock);
        s = cyc; start8 = 1'b1;
        push_exp(0, 0, s + 1, 8'h10, 3'd0);
        push_exp(0, 0, s + 2, 8'h12, 3'd2);
        push_exp(0, 0, s + 3, 8'h15, 3'd5);
        push_exp(0, 0, s + 4, 8'h17, 3'd7);
        push_exp(0, 1, s + 5, 8'h02, 3'd0);
        @(negedge clock) start8 = 1'b0;
        repeat (6) @(negedge clock);

        // Start held high: the start seen in the done cycle launches a second scan
        s = cyc; io_mode = 1'b1; io_mask = 8'h03; start8 = 1'b1;
        push_exp(0, 0, s + 1, 8'h10, 3'd0);
        push_exp(0, 0, s + 2, 8'h11, 3'd1);
        push_exp(0, 1, s + 3, 8'h02, 3'd0);
        push_exp(0, 0, s + 4, 8'h10, 3'd0);
        push_exp(0, 0, s + 5, 8'h11, 3'd1);
        push_exp(0, 1, s + 6, 8'h02, 3'd0);
        repeat (4) @(negedge clock);
        start8 = 1'b0;
        repeat (5) @(negedge clock);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL missing_events actual %0d still pending required 0 (next inst=%0d kind=%0d cyc=%0d)",
                     q.size(), q[0].inst, q[0].kind, q[0].cyc);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_scan_nto1.md
Name: mux_scan_nto1

Overview:
- Parametrised successor to the team's fixed 8-to-1 bit multiplexer.
- Selects one W-bit channel out of N input channels and registers it onto a valid/ready output port.
- Direct mode: a single addressed read of one channel.
- Scan mode: walks every channel enabled in a mask, in ascending order, and presents each in turn.
- Sits between parallel sensor/data buses and a serial consumer (UART/packer).

Parameters:
N, 8, number of input channels (2..64, need not be a power of two)
W, 8, data width per channel
SEL_W, clog2(N), width of channel index

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-low reset (0 = reset), sampled on clock rising edge
io_in  input  N*W  packed channels; channel k = io_in[k*W +: W]
io_sel  input  SEL_W  channel index for direct mode
io_mode  input  1  0 = direct, 1 = scan
io_mask  input  N  channel-enable mask for scan mode
io_start  input  1  start request, single-cycle or level
io_out  output  W  selected channel data (registered)
io_out_ch  output  SEL_W  index of channel on io_out
io_out_valid  output  1  io_out/io_out_ch hold a valid word
io_out_ready  input  1  consumer accepts word when high with io_out_valid
io_busy  output  1  operation in progress; io_start ignored
io_done  output  1  one-cycle pulse: operation complete
io_err  output  1  one-cycle pulse: direct select out of range

Behaviour:
- Reset (reset==0 at an edge):
  - FSM goes to IDLE.
  - io_out, io_out_ch, io_out_valid, io_busy, io_done and io_err all go to 0.
  - Latched mask is cleared.
  - Reset mid-operation aborts the operation; no io_done is issued.
- FSM states: IDLE and HOLD. io_busy = (state==HOLD).
- IDLE with io_start=1, io_mode=0 (direct), io_sel<N:
  - Next edge: io_out = io_in[io_sel], io_out_ch = io_sel, io_out_valid = 1, state -> HOLD.
  - Latency is 1 cycle from start to valid.
- IDLE with io_start=1, io_mode=0, io_sel>=N (only possible when N is not a power of two):
  - Next cycle: io_err=1 and io_done=1 for one cycle.
  - No valid word; state stays IDLE.
- IDLE with io_start=1, io_mode=1 (scan):
  - io_mask is latched into mask_q.
  - If mask==0: next cycle io_done=1 for one cycle, no valid word, state stays IDLE.
  - Otherwise: next edge loads the lowest enabled channel into io_out/io_out_ch, io_out_valid=1, state -> HOLD.
- HOLD:
  - io_out, io_out_ch and io_out_valid are held stable while io_out_ready=0, for any number of cycles.
  - Transfer happens on a cycle with io_out_valid & io_out_ready.
- After a transfer in scan mode:
  - The next enabled channel above io_out_ch is found in the same cycle (priority search, no idle cycles between words).
  - If one exists: next edge loads it with io_out_valid still 1. Back-to-back rate is one word per cycle.
  - If none remains: next edge drives io_out_valid=0 and io_done=1 (one cycle), state -> IDLE.
- After a transfer in direct mode: next edge drives io_out_valid=0 and io_done=1, state -> IDLE.
- Data sampling:
  - io_in is sampled at the edge that loads each channel, not at io_start.
  - Later changes on io_in do not disturb a held word.
- Mask handling: io_mask changes during a scan are ignored (mask_q is used).
- io_start:
  - Ignored while io_busy=1.
  - Accepted in the same cycle io_done is high (state is IDLE), so the next operation can begin immediately.
- io_out retains its last value after io_done; it is only meaningful while io_out_valid=1.
- Scan never wraps: channel N-1 is the last candidate, and each scan visits each enabled channel exactly once.

Test Plan:
- Direct: N=8, W=8, channel k = 0x10+k, start with mode=0, sel=5, ready=1 -> cycle+1: out=0x15, ch=5, valid=1; cycle+2: valid=0, done=1.
- Scan, full rate: mask=0b10100101, ready=1 -> valid on 4 consecutive cycles with ch=0,2,5,7 and data 0x10,0x12,0x15,0x17, then done=1 one cycle, busy=0.
- Backpressure and start filtering: same scan with ready low for 3 cycles on ch=2 -> out=0x12 held stable; change io_in[2] and io_mask meanwhile -> no effect on the held word or the visited channel set; a start pulsed while busy=1 is ignored.
- Empty mask and range error: scan with mask=0 -> done=1 at cycle+1, valid never set. With N=6, direct sel=7 -> err=1 and done=1 at cycle+1, valid stays 0.
- Reset mid-scan: assert reset=0 while in HOLD on ch=2 -> next edge all outputs 0, state IDLE, no done. Deassert reset and start a new scan -> begins at the lowest enabled channel.
- Back-to-back: start held high with mode=1, mask=0b11 -> ch0, ch1, done; the start seen in the done cycle launches a second scan whose ch0 is valid the next cycle.
